clock_period_meter: RTL

CLOCK_PERIOD_METER -- requirements
Module: clock_period_meter

---
 rtl/clock_period_meter_if.sv | 27 ++
 rtl/clock_period_meter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/clock_period_meter_if.sv
// Measurement bundle between a divided-clock source and the period meter.
// The source side drives sig_in; the meter side reports period, period_valid, locked and lost.
interface clock_period_meter_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 sig_in;
    logic [CNT_WIDTH-1:0] period;
    logic                 period_valid;
    logic                 locked;
    logic                 lost;

    modport master (
        output sig_in,
        input  period,
        input  period_valid,
        input  locked,
        input  lost
    );

    modport slave (
        input  sig_in,
        output period,
        output period_valid,
        output locked,
        output lost
    );
endinterface

// File: rtl/clock_period_meter.sv
// Measures the sig_in period in clk_in cycles and tracks lock and loss of the input.
// Define CLOCK_PERIOD_METER_AVG_EN to publish a 4-sample running mean instead of raw periods.
module clock_period_meter #(
    parameter int CNT_WIDTH  = 16,
    parameter int EXP_PERIOD = 10,
    parameter int TOL        = 1,
    parameter int TIMEOUT    = 1024,
    parameter int LOCK_COUNT = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    clock_period_meter_if.slave  bus
);
    localparam int LW = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT - 1);
    localparam logic [CNT_WIDTH:0]   LO_V    = (CNT_WIDTH+1)'(EXP_PERIOD - TOL);
    localparam logic [CNT_WIDTH:0]   HI_V    = (CNT_WIDTH+1)'(EXP_PERIOD + TOL);
    localparam logic [LW-1:0]        LOCK_MAX = LW'(LOCK_COUNT);

    typedef enum logic [1:0] {ARM, MEASURE, LOST} state_t;

    state_t               state, state_nx;
    logic                 s1, s2, s3;
    logic                 rise;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] meas;
    logic                 timeout;
    logic                 in_range;
    logic                 pub;
    logic                 go_lost;
    logic [LW-1:0]        lock_cnt, lock_nx;
    logic [CNT_WIDTH-1:0] period_q;
    logic                 valid_q;
    logic                 locked_q;
    logic                 lost_q;

    assign rise     = s2 & ~s3;
    assign meas     = cnt + CNT_WIDTH'(1);
    assign timeout  = (cnt == TO_LAST);
    assign in_range = ({1'b0, meas} >= LO_V) && ({1'b0, meas} <= HI_V);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (rise)
            cnt <= '0;
        else if (cnt != CNT_MAX)
            cnt <= cnt + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n)
            state <= ARM;
        else
            state <= state_nx;
    end

    // A rise always wins over a coincident timeout.
    always_comb begin
        state_nx = state;
        unique case (state)
            ARM:     if (rise) state_nx = MEASURE;
            MEASURE: if (!rise && timeout) state_nx = LOST;
            LOST:    if (rise) state_nx = MEASURE;
            default: state_nx = ARM;
        endcase
    end

    always_comb begin
        pub     = 1'b0;
        go_lost = 1'b0;
        unique case (state)
            MEASURE: begin
                pub     = rise;
                go_lost = !rise && timeout;
            end
            default: ;
        endcase
    end

    always_comb begin
        lock_nx = lock_cnt;
        if (go_lost)
            lock_nx = '0;
        else if (pub && !in_range)
            lock_nx = '0;
        else if (pub && lock_cnt != LOCK_MAX)
            lock_nx = lock_cnt + LW'(1);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt <= '0;
            locked_q <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            lock_cnt <= lock_nx;
            locked_q <= (lock_nx == LOCK_MAX);
            lost_q   <= (state_nx == LOST);
        end
    end

`ifdef CLOCK_PERIOD_METER_AVG_EN
    logic [2:0][CNT_WIDTH-1:0] hist;
    logic [1:0]                hcnt;
    logic [CNT_WIDTH+1:0]      sum;

    assign sum = {2'b00, meas} + {2'b00, hist[0]}
               + {2'b00, hist[1]} + {2'b00, hist[2]};

    // hist holds the three previous raw periods; the fourth is the live one.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            hist     <= '0;
            hcnt     <= '0;
            valid_q  <= 1'b0;
            period_q <= '0;
        end else begin
            valid_q <= 1'b0;
            if (go_lost) begin
                hist <= '0;
                hcnt <= '0;
            end else if (pub) begin
                hist <= {hist[1:0], meas};
                if (hcnt != 2'd3)
                    hcnt <= hcnt + 2'd1;
                if (hcnt == 2'd3) begin
                    valid_q  <= 1'b1;
                    period_q <= CNT_WIDTH'(sum >> 2);
                end
            end
        end
    end
`else
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            period_q <= '0;
        end else begin
            valid_q <= pub;
            if (pub)
                period_q <= meas;
        end
    end
`endif

    assign bus.period       = period_q;
    assign bus.period_valid = valid_q;
    assign bus.locked       = locked_q;
    assign bus.lost         = lost_q;
endmodule
